// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its two requesters (fetch, data) and the memory.
// master = requesters + memory side, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter onto one single-port synchronous memory, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating priority instead of data-first with a starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    logic [1:0]        state;
    logic              owner;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              win_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;

    // On contention the port that did not win last time goes first.
    always_comb win_d = bus.d_req && (!bus.if_req || last_owner == OWN_IF);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner <= OWN_IF;
        end else if (state == IDLE && (bus.if_req || bus.d_req)) begin
            last_owner <= win_d;
        end
    end
`else
    logic [3:0] starve_cnt;

    always_comb win_d = bus.d_req && !(bus.if_req && starve_cnt == 4'(STARVE_MAX));

    // Counted at grant time: only data wins taken over a waiting fetch count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == REQ) begin
            if (owner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (bus.if_req && starve_cnt != 4'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            lat_cnt    <= '0;
            if_rdata_r <= '0;
            d_rdata_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        owner   <= win_d;
                        we_r    <= win_d && bus.d_we;
                        addr_r  <= win_d ? bus.d_addr : bus.if_addr;
                        wdata_r <= win_d ? bus.d_wdata : '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    lat_cnt <= 4'(MEM_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= RESP;
                        if (!we_r) begin
                            if (owner == OWN_D) d_rdata_r  <= bus.mem_rdata;
                            else                if_rdata_r <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory address/data stay on the latched values through WAIT.
    assign bus.mem_en    = (state == REQ);
    assign bus.mem_we    = (state == REQ) && we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;

    assign bus.if_gnt    = (state == REQ)  && (owner == OWN_IF);
    assign bus.d_gnt     = (state == REQ)  && (owner == OWN_D);
    assign bus.if_rvalid = (state == RESP) && (owner == OWN_IF);
    assign bus.d_rvalid  = (state == RESP) && (owner == OWN_D);
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int SMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Initial memory image: address 0x132 (aliased to word 0x32) holds 0x40001C00.
    function automatic logic [31:0] dflt(input logic [5:0] a);
        return 32'h40001C00 ^ ({26'd0, a ^ 6'h32} * 32'h9E3779B1);
    endfunction

    // Memory: MEM_LAT cycles from mem_en to data; junk on mem_rdata at every other time.
    logic [31:0] tmem [64];
    logic [63:0] tvld = '0;
    logic [31:0] rpipe [LAT];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            tmem[bus.mem_addr[5:0]] <= bus.mem_wdata;
            tvld[bus.mem_addr[5:0]] <= 1'b1;
        end
        if (bus.mem_en)
            rpipe[0] <= tvld[bus.mem_addr[5:0]] ? tmem[bus.mem_addr[5:0]] : dflt(bus.mem_addr[5:0]);
        else
            rpipe[0] <= $urandom;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.mem_rdata = rpipe[LAT-1];

    // Reference model: k = edges since the current transaction was accepted (-1 when none).
    int          k = -1;
    int          starve = 0;
    logic        m_last_d = 1'b0;
    logic        m_own = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rd = '0;
    logic [31:0] e_ifr = '0;
    logic [31:0] e_dr = '0;
    logic [31:0] mm [64];
    logic [63:0] mv = '0;
    logic e_mem_en = 0, e_mem_we = 0, e_if_gnt = 0, e_d_gnt = 0;
    logic e_if_rv = 0, e_d_rv = 0, e_busy = 0, e_addr_chk = 0, e_wd_chk = 0;

    always @(posedge clk) begin
        logic own;
        if (!rst) begin
            k = -1; starve = 0; m_last_d = 1'b0; e_ifr = '0; e_dr = '0;
        end else begin
            if (k >= 0) k++;
            if (k == LAT + 3) k = -1;
            if (k == 1) begin
                if (!m_own) starve = 0;
                else if (bus.if_req && starve < SMAX) starve++;
            end
            if (k == LAT + 1 && !m_we) begin
                if (m_own) e_dr = m_rd;
                else       e_ifr = m_rd;
            end
            if (k < 0 && (bus.if_req || bus.d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
                own = (bus.if_req && bus.d_req) ? !m_last_d : bus.d_req;
                m_last_d = own;
`else
                own = bus.d_req && !(bus.if_req && starve == SMAX);
`endif
                m_own   = own;
                m_we    = own && bus.d_we;
                m_addr  = own ? bus.d_addr : bus.if_addr;
                m_wdata = own ? bus.d_wdata : '0;
                m_rd    = mv[m_addr[5:0]] ? mm[m_addr[5:0]] : dflt(m_addr[5:0]);
                if (m_we) begin
                    mm[m_addr[5:0]] = m_wdata;
                    mv[m_addr[5:0]] = 1'b1;
                end
                k = 0;
            end
        end
        e_mem_en   = (k == 0);
        e_mem_we   = (k == 0) && m_we;
        e_if_gnt   = (k == 0) && !m_own;
        e_d_gnt    = (k == 0) && m_own;
        e_if_rv    = (k == LAT + 1) && !m_own;
        e_d_rv     = (k == LAT + 1) && m_own;
        e_busy     = (k >= 0) && (k <= LAT + 1);
        e_addr_chk = (k >= 0) && (k <= LAT);
        e_wd_chk   = (k == 0) && m_we;
    end

    always @(negedge clk) begin
        chk1("if_gnt", bus.if_gnt, e_if_gnt);
        chk1("d_gnt", bus.d_gnt, e_d_gnt);
        chk1("if_rvalid", bus.if_rvalid, e_if_rv);
        chk1("d_rvalid", bus.d_rvalid, e_d_rv);
        chk1("mem_en", bus.mem_en, e_mem_en);
        chk1("busy", bus.busy, e_busy);
        chk("if_rdata", bus.if_rdata, e_ifr);
        chk("d_rdata", bus.d_rdata, e_dr);
        if (e_mem_en)   chk1("mem_we", bus.mem_we, e_mem_we);
        if (e_addr_chk) chk("mem_addr", bus.mem_addr, m_addr);
        if (e_wd_chk)   chk("mem_wdata", bus.mem_wdata, m_wdata);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction from a single port; returns grant/response cycle offsets and observed values.
    task automatic txn(input logic isd, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       output int gc, output int rc, output logic [31:0] maddr,
                       output logic mwe, output logic [31:0] mwd, output logic [31:0] rdat);
        gc = -1; rc = -1; maddr = '0; mwe = 1'b0; mwd = '0; rdat = '0;
        @(posedge clk); #1;
        if (isd) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = a;
        end
        for (int c = 0; c < LAT + 8; c++) begin
            @(negedge clk);
            if ((isd ? bus.d_gnt : bus.if_gnt) && gc < 0) begin
                gc = c; maddr = bus.mem_addr; mwe = bus.mem_we; mwd = bus.mem_wdata;
            end
            if (isd ? bus.d_rvalid : bus.if_rvalid) begin
                rc = c; rdat = isd ? bus.d_rdata : bus.if_rdata;
            end
            @(posedge clk); #1;
            if (gc >= 0) begin
                if (isd) bus.d_req = 1'b0;
                else     bus.if_req = 1'b0;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int          gc, rc, seen;
        logic [31:0] ma, mwd, rd;
        logic        mwe, ig, dg;
        byte         gq[$];
        string       ord;

        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'h1234;

        // Reset held with both requests active
        repeat (3) begin
            @(negedge clk);
            chk1("rst_mem_en", bus.mem_en, 1'b0);
            chk1("rst_if_gnt", bus.if_gnt, 1'b0);
            chk1("rst_d_gnt", bus.d_gnt, 1'b0);
            chk1("rst_busy", bus.busy, 1'b0);
            chk("rst_if_rdata", bus.if_rdata, 32'h0);
        end
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        rst = 1'b1;

        // Fetch
        txn(1'b0, 1'b0, 32'h132, 32'h0, gc, rc, ma, mwe, mwd, rd);
        chk("fetch_gnt_cycle", 32'(gc), 32'd1);
        chk("fetch_mem_addr", ma, 32'h132);
        chk1("fetch_mem_we", mwe, 1'b0);
        chk("fetch_rvalid_cycle", 32'(rc), 32'(2 + LAT));
        chk("fetch_rdata", rd, 32'h40001C00);

        // Store then load
        txn(1'b1, 1'b1, 32'h10, 32'hDEADBEAF, gc, rc, ma, mwe, mwd, rd);
        chk1("store_mem_we", mwe, 1'b1);
        chk("store_mem_wdata", mwd, 32'hDEADBEAF);
        chk("store_mem_addr", ma, 32'h10);
        chk("store_rvalid_cycle", 32'(rc), 32'(2 + LAT));
        chk("store_d_rdata_unchanged", bus.d_rdata, 32'h0);
        txn(1'b1, 1'b0, 32'h10, 32'h0, gc, rc, ma, mwe, mwd, rd);
        chk("load_rdata", rd, 32'hDEADBEAF);
        chk("load_if_rdata_held", bus.if_rdata, 32'h40001C00);

        // Contention with both requests held continuously
        pulse_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h21;
        for (int c = 0; c < 8 * (3 + LAT) + 4; c++) begin
            @(negedge clk);
            if (bus.d_gnt)  gq.push_back(8'h44);
            if (bus.if_gnt) gq.push_back(8'h46);
        end
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ord = "DFDFDFDF";
`else
        ord = "DDDFDDDF";
`endif
        chk1("grant_count", gq.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < gq.size(); i++)
            chk($sformatf("grant_order_%0d", i), {24'd0, gq[i]}, {24'd0, ord[i]});

        // Reset in the second WAIT cycle aborts the load
        repeat (LAT + 4) @(posedge clk);
        #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h5;
        gc = -1;
        for (int c = 0; c < 10 && gc < 0; c++) begin
            @(negedge clk);
            if (bus.d_gnt) gc = c;
        end
        chk("abort_gnt_cycle", 32'(gc), 32'd1);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk1("abort_idle", bus.busy, 1'b0);
        seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (bus.d_rvalid || bus.if_rvalid) seen = 1;
        end
        chk("abort_no_rvalid", 32'(seen), 32'd0);

        // Random traffic with occasional reset pulses
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ig = bus.if_gnt; dg = bus.d_gnt;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) != 0);
            if (!bus.if_req || ig) begin
                bus.if_req  = ($urandom_range(0, 2) != 0);
                bus.if_addr = {26'd0, 6'($urandom)};
            end
            if (!bus.d_req || dg) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = 1'($urandom);
                bus.d_addr  = {26'd0, 6'($urandom)};
                bus.d_wdata = $urandom;
            end
        end
        @(posedge clk); #1;
        rst = 1'b1; bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (LAT + 6) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, word-addressed synchronous memory between two requesters: the core's instruction-fetch port (pc-driven) and its data port (ldr/str).
- Runs a small state machine that sequences exactly one memory transaction at a time and returns the read data to the requester that issued it.
- Data requests win by default. A starvation counter guarantees that fetch makes forward progress.
- Sits between test_processor_assembly-class cores and the program/data memory.

Parameters:
- ADDR_W, 32, width of all address buses.
- DATA_W, 32, width of all data buses.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata being valid. Legal range 1..15.
- STARVE_MAX, 3, number of consecutive data wins over a pending fetch before fetch is forced. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; must be held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word; held until the next fetch response.
- d_req  in  1  data request; must be held with d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete.
- d_rdata  out  DATA_W  load data; held until the next load response. Unchanged by stores.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state = IDLE, starve_cnt = 0.
  - All outputs 0, including if_rdata and d_rdata.
  - Reset takes effect in any state and aborts any in-flight transaction. No gnt or rvalid is produced for an aborted transaction.
- State IDLE: requests are sampled at each edge.
  - Neither request: stay in IDLE.
  - Only one request: that requester wins.
  - Both requests: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - On a winner: latch owner, we, addr and wdata, then go to REQ. A fetch is always a read (mem_we = 0).
- State REQ (1 cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata are driven from the latched registers.
  - The owner's gnt = 1 in the same cycle; the requester may drop req or change operands from the next cycle.
  - Next state: WAIT.
- State WAIT (MEM_LAT cycles, counted with a down-counter): mem_en = 0 and mem_addr holds its value.
- Data capture: on the edge ending the last WAIT cycle, mem_rdata is captured into the owner's rdata register, only for reads.
- State RESP (1 cycle):
  - The owner's rvalid = 1.
  - Next state: IDLE.
- Timing:
  - Request seen in IDLE at cycle n means gnt at n+1, rvalid at n+2+MEM_LAT.
  - Throughput is one transaction per 3+MEM_LAT cycles.
- Starvation counter:
  - On each data grant while if_req == 1: starve_cnt++ (saturates at STARVE_MAX).
  - On a fetch grant: starve_cnt = 0.
  - On a data grant with if_req == 0: starve_cnt unchanged.
- A req still high in the IDLE cycle after RESP is treated as a new request.
- gnt and rvalid are never asserted for both ports in the same cycle.
- At most one transaction is outstanding at any time.
- Requests arriving during REQ, WAIT or RESP are ignored until IDLE; the requester keeps them held.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Fixed data priority and starve_cnt are removed.
  - A 1-bit last_owner register (reset value = fetch) gives priority to the port that did not win last when both request.
  - A single requester always wins.
- Undefined: data priority with starvation guard, as described under Behaviour.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both req=1 -> mem_en, if_gnt and d_gnt stay 0; busy=0; if_rdata=0.
- Fetch: if_req=1, if_addr=0x132, memory returns 0x40001C00, MEM_LAT=1 -> if_gnt at n+1 with mem_addr=0x132 and mem_we=0; if_rvalid and if_rdata=0x40001C00 at n+3.
- Store then load:
  - d_we=1, d_addr=0x10, d_wdata=0xDEADBEAF -> mem_we=1 with that data.
  - A load from 0x10 then gives d_rdata=0xDEADBEAF.
  - if_rdata is unchanged throughout.
- Contention: both req held continuously, STARVE_MAX=3 -> grant order D,D,D,F,D,D,D,F; starve_cnt reaches 3 before each fetch win.
- Reset mid-WAIT (MEM_LAT=4): assert rst=0 in the 2nd WAIT cycle -> no rvalid is produced; state=IDLE at the next edge.
- ARB_ROUND_ROBIN_EN defined, both req held -> grant order D,F,D,F,... (last_owner=fetch after reset, so data wins first).
